// File: rtl/booth_product_accumulator.sv
// ----------------------------------------------------------------------------
// booth_product_accumulator
//
// Sums N_TERMS consecutive signed products from the Booth multiplier into one
// signed dot-product result. Products arrive over a valid/ready handshake and
// each result is held on a valid/ready output port until it is taken.
//
// Build option:
//   BOOTH_ACC_SAT_EN  defined   -> accumulator saturates on signed overflow
//                     undefined -> accumulator wraps modulo 2^ACC_W
//   out_ovf behaves the same in both builds.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-high reset
//   in_valid   in   product present on product
//   in_ready   out  block can accept a product (decoded from state)
//   product    in   PROD_W signed product
//   out_valid  out  result present on out_data/out_ovf (registered)
//   out_ready  in   consumer takes the result
//   out_data   out  ACC_W signed sum of N_TERMS products (registered)
//   out_ovf    out  signed overflow seen while forming this result
// ----------------------------------------------------------------------------
module booth_product_accumulator #(
    parameter int PROD_W  = 8,
    parameter int ACC_W   = 10,
    parameter int N_TERMS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_ovf
);

    // state  | meaning
    // S_ACC  | accepting products, accumulating the current block
    // S_HOLD | result presented, waiting for out_ready

    localparam int CNT_W = $clog2(N_TERMS + 1);

    typedef enum logic {S_ACC = 1'b0, S_HOLD = 1'b1} state_t;

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf;
    logic                    accept;
    logic                    last_term;
    logic                    term_ovf;
    logic [ACC_W:0]          sum;

    assign accept    = in_valid && (state == S_ACC);
    assign last_term = (cnt == CNT_W'(N_TERMS - 1));

    // One guard bit: the sum overflowed ACC_W when the guard bit and the
    // ACC_W sign bit disagree; the guard bit then holds the true sign.
    always_comb begin
        sum = {acc[ACC_W-1], acc}
            + {{(ACC_W + 1 - PROD_W){product[PROD_W-1]}}, product};
        term_ovf = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef BOOTH_ACC_SAT_EN
        if (term_ovf) begin
            acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                 : {1'b0, {(ACC_W - 1){1'b1}}};
        end else begin
            acc_nxt = sum[ACC_W-1:0];
        end
`else
        acc_nxt = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_ACC: begin
                in_ready = 1'b1;
                if (accept && last_term) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_nxt = S_ACC;
                end
            end
            default: state_nxt = S_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            if (last_term) begin
                out_data  <= acc_nxt;
                out_ovf   <= ovf | term_ovf;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
            end else begin
                acc <= acc_nxt;
                cnt <= cnt + CNT_W'(1);
                ovf <= ovf | term_ovf;
            end
        end else if (state == S_HOLD && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
module tb_booth_product_accumulator;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] product;
    logic              out_valid;
    logic              out_ready;
    logic signed [9:0] out_data;
    logic              out_ovf;

    int errors = 0;
    int checks = 0;

    booth_product_accumulator #(
        .PROD_W (8),
        .ACC_W  (10),
        .N_TERMS(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .product  (product),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [7:0][7:0] p;
        int             exp_data;
        int             exp_ovf;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] terms[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_terms(input logic [7:0] v);
        for (int i = 0; i < 8; i++) terms[i] = v;
    endtask

    task automatic feed_terms(input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            @(negedge clk);
            in_valid = 1'b1;
            product  = terms[i];
            guard    = 0;
            while (!in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) check("in_ready_timeout", 0, 1);
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    // Called right after the edge that accepted the last term.
    task automatic check_result(input string name, input int exp_data, input int exp_ovf);
        @(negedge clk);
        check({name, "_out_valid"}, int'(out_valid), 1);
        check({name, "_out_data"}, int'(out_data), exp_data);
        check({name, "_out_ovf"}, int'(out_ovf), exp_ovf);
        check({name, "_in_ready_hold"}, int'(in_ready), 0);
        if (out_ready) begin
            @(negedge clk);
            check({name, "_in_ready_back"}, int'(in_ready), 1);
            check({name, "_out_valid_drop"}, int'(out_valid), 0);
        end
    endtask

    initial begin
        vecs[0].name = "mixed";
        vecs[0].p[0] = 8'(3);   vecs[0].p[1] = 8'(-42); vecs[0].p[2] = 8'(10);
        vecs[0].p[3] = 8'(25);  vecs[0].p[4] = 8'(0);   vecs[0].p[5] = 8'(0);
        vecs[0].p[6] = 8'(0);   vecs[0].p[7] = 8'(0);
        vecs[0].exp_data = -4;  vecs[0].exp_ovf = 0;

        vecs[1].name = "pos64";
        for (int i = 0; i < 8; i++) vecs[1].p[i] = 8'(64);
`ifdef BOOTH_ACC_SAT_EN
        vecs[1].exp_data = 511;
`else
        vecs[1].exp_data = -512;
`endif
        vecs[1].exp_ovf = 1;

        vecs[2].name = "neg56";
        for (int i = 0; i < 8; i++) vecs[2].p[i] = 8'(-56);
        vecs[2].exp_data = -448; vecs[2].exp_ovf = 0;

        vecs[3].name = "pos127";
        for (int i = 0; i < 8; i++) vecs[3].p[i] = 8'(127);
`ifdef BOOTH_ACC_SAT_EN
        vecs[3].exp_data = 511;
`else
        vecs[3].exp_data = -8;
`endif
        vecs[3].exp_ovf = 1;

        vecs[4].name = "neg128";
        for (int i = 0; i < 8; i++) vecs[4].p[i] = 8'(-128);
`ifdef BOOTH_ACC_SAT_EN
        vecs[4].exp_data = -512;
`else
        vecs[4].exp_data = 0;
`endif
        vecs[4].exp_ovf = 1;

        vecs[5].name = "ramp";
        for (int i = 0; i < 8; i++) vecs[5].p[i] = 8'(i + 1);
        vecs[5].exp_data = 36; vecs[5].exp_ovf = 0;

        vecs[6].name = "ovf_then_back";
        for (int i = 0; i < 5; i++) vecs[6].p[i] = 8'(127);
        for (int i = 5; i < 8; i++) vecs[6].p[i] = 8'(-100);
`ifdef BOOTH_ACC_SAT_EN
        vecs[6].exp_data = 211;
`else
        vecs[6].exp_data = 335;
`endif
        vecs[6].exp_ovf = 1;

        rst       = 1'b1;
        in_valid  = 1'b0;
        product   = '0;
        out_ready = 1'b1;

        // Reset is visible before any clock edge.
        #2;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_ovf", int'(out_ovf), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 8; i++) terms[i] = vecs[v].p[i];
            feed_terms(8);
            check_result(vecs[v].name, vecs[v].exp_data, vecs[v].exp_ovf);
        end

        // Backpressure: held result, in_valid ignored.
        out_ready = 1'b0;
        fill_terms(8'(1));
        feed_terms(8);
        check_result("bp_first", 8, 0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            product  = 8'sd7;
            @(posedge clk);
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_data", int'(out_data), 8);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_out_valid", int'(out_valid), 0);
        fill_terms(8'(7));
        feed_terms(8);
        check_result("bp_sevens", 56, 0);

        // Asynchronous reset mid-cycle while a result is held.
        out_ready = 1'b0;
        fill_terms(8'(64));
        feed_terms(8);
        @(negedge clk);
        check("hold_before_rst", int'(out_valid), 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data", int'(out_data), 0);
        check("midrst_out_ovf", int'(out_ovf), 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;

        // Reset discards a partial block.
        fill_terms(8'(10));
        feed_terms(3);
        @(negedge clk);
        rst = 1'b1;
        #2 rst = 1'b0;
        fill_terms(8'(1));
        feed_terms(8);
        check_result("after_partial_rst", 8, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
